// File: rtl/axi_addr_remap_stage_if.sv
// Single address channel (valid/ready/addr) between remap stage neighbours.
// master drives valid/addr, slave drives ready.
interface axi_addr_remap_stage_if #(
    parameter int unsigned AddrWidth = 32
);
    logic                 valid;
    logic                 ready;
    logic [AddrWidth-1:0] addr;

    modport master (output valid, output addr, input ready);
    modport slave  (input valid, input addr, output ready);
endinterface

// File: rtl/axi_addr_remap_stage.sv
// Registered AW/AR address-translation stage with a first-match base/mask/offset rule table.
// Optional table-miss counter is built when AXI_REMAP_MISS_CNT_EN is defined.
module axi_addr_remap_stage #(
    parameter int unsigned NumRules     = 4,
    parameter int unsigned SlvAddrWidth = 32,
    parameter int unsigned MstAddrWidth = 32,
    localparam int unsigned IdxWidth    = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    axi_addr_remap_stage_if.slave       slv_aw,
    axi_addr_remap_stage_if.master      mst_aw,
    axi_addr_remap_stage_if.slave       slv_ar,
    axi_addr_remap_stage_if.master      mst_ar,
    input  logic                        cfg_we,
    input  logic [IdxWidth-1:0]         cfg_idx,
    input  logic                        cfg_en,
    input  logic [SlvAddrWidth-1:0]     cfg_base,
    input  logic [SlvAddrWidth-1:0]     cfg_mask,
    input  logic [MstAddrWidth-1:0]     cfg_offset,
    output logic [15:0]                 miss_cnt
);
    localparam int unsigned MaxWidth =
        (SlvAddrWidth > MstAddrWidth) ? SlvAddrWidth : MstAddrWidth;

    typedef logic [SlvAddrWidth-1:0] slv_addr_t;
    typedef logic [MstAddrWidth-1:0] mst_addr_t;
    typedef enum logic {StEmpty, StFull} state_e;

    // Zero-extend or truncate a slave-side value to master width.
    function automatic mst_addr_t resize(input slv_addr_t a);
        logic [MaxWidth-1:0] wide;
        wide = MaxWidth'(a);
        return wide[MstAddrWidth-1:0];
    endfunction

    logic      rule_en_q   [NumRules];
    slv_addr_t rule_base_q [NumRules];
    slv_addr_t rule_mask_q [NumRules];
    mst_addr_t rule_off_q  [NumRules];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NumRules); i++) begin
                rule_en_q[i]   <= 1'b0;
                rule_base_q[i] <= '0;
                rule_mask_q[i] <= '0;
                rule_off_q[i]  <= '0;
            end
        end else if (cfg_we && (32'(cfg_idx) < NumRules)) begin
            rule_en_q[cfg_idx]   <= cfg_en;
            rule_base_q[cfg_idx] <= cfg_base;
            rule_mask_q[cfg_idx] <= cfg_mask;
            rule_off_q[cfg_idx]  <= cfg_offset;
        end
    end

    logic      aw_hit, ar_hit;
    mst_addr_t aw_xlat, ar_xlat;

    // Walk from the top index down so the lowest-index hit is the final assignment.
    always_comb begin
        aw_hit  = 1'b0;
        ar_hit  = 1'b0;
        aw_xlat = resize(slv_aw.addr);
        ar_xlat = resize(slv_ar.addr);
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if (rule_en_q[i] &&
                ((slv_aw.addr & rule_mask_q[i]) == (rule_base_q[i] & rule_mask_q[i]))) begin
                aw_hit  = 1'b1;
                aw_xlat = (rule_off_q[i] & resize(rule_mask_q[i])) |
                          (resize(slv_aw.addr) & ~resize(rule_mask_q[i]));
            end
            if (rule_en_q[i] &&
                ((slv_ar.addr & rule_mask_q[i]) == (rule_base_q[i] & rule_mask_q[i]))) begin
                ar_hit  = 1'b1;
                ar_xlat = (rule_off_q[i] & resize(rule_mask_q[i])) |
                          (resize(slv_ar.addr) & ~resize(rule_mask_q[i]));
            end
        end
    end

    state_e    aw_state_q, ar_state_q;
    mst_addr_t aw_addr_q, ar_addr_q;
    logic      aw_ready, ar_ready, aw_cap, ar_cap;

    assign aw_ready     = (aw_state_q == StEmpty) || mst_aw.ready;
    assign ar_ready     = (ar_state_q == StEmpty) || mst_ar.ready;
    assign aw_cap       = slv_aw.valid && aw_ready;
    assign ar_cap       = slv_ar.valid && ar_ready;
    assign slv_aw.ready = aw_ready;
    assign slv_ar.ready = ar_ready;
    assign mst_aw.valid = (aw_state_q == StFull);
    assign mst_ar.valid = (ar_state_q == StFull);
    assign mst_aw.addr  = aw_addr_q;
    assign mst_ar.addr  = ar_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_state_q <= StEmpty;
            aw_addr_q  <= '0;
        end else begin
            case (aw_state_q)
                StEmpty: if (slv_aw.valid) begin
                    aw_state_q <= StFull;
                    aw_addr_q  <= aw_xlat;
                end
                StFull: if (mst_aw.ready) begin
                    if (slv_aw.valid) aw_addr_q  <= aw_xlat;
                    else              aw_state_q <= StEmpty;
                end
                default: aw_state_q <= StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_state_q <= StEmpty;
            ar_addr_q  <= '0;
        end else begin
            case (ar_state_q)
                StEmpty: if (slv_ar.valid) begin
                    ar_state_q <= StFull;
                    ar_addr_q  <= ar_xlat;
                end
                StFull: if (mst_ar.ready) begin
                    if (slv_ar.valid) ar_addr_q  <= ar_xlat;
                    else              ar_state_q <= StEmpty;
                end
                default: ar_state_q <= StEmpty;
            endcase
        end
    end

`ifdef AXI_REMAP_MISS_CNT_EN
    logic [15:0] miss_cnt_q;
    logic [1:0]  miss_inc;
    logic [16:0] miss_sum;

    assign miss_inc = {1'b0, aw_cap && !aw_hit} + {1'b0, ar_cap && !ar_hit};
    assign miss_sum = {1'b0, miss_cnt_q} + {15'b0, miss_inc};

    always_ff @(posedge clk) begin
        if (rst)              miss_cnt_q <= '0;
        else if (miss_sum[16]) miss_cnt_q <= 16'hFFFF;
        else                  miss_cnt_q <= miss_sum[15:0];
    end

    assign miss_cnt = miss_cnt_q;
`else
    logic unused_hits;
    assign unused_hits = aw_hit ^ ar_hit;
    assign miss_cnt    = '0;
`endif
endmodule

// File: tb/tb_axi_addr_remap_stage.sv
// Bench for axi_addr_remap_stage: directed steps then random traffic against a queue-based model.
module tb_axi_addr_remap_stage;
    logic        clk, rst;
    logic        cfg_we, cfg_en;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_base, cfg_mask, cfg_offset;
    logic [15:0] miss_cnt;

    axi_addr_remap_stage_if #(.AddrWidth(32)) slv_aw_if ();
    axi_addr_remap_stage_if #(.AddrWidth(32)) mst_aw_if ();
    axi_addr_remap_stage_if #(.AddrWidth(32)) slv_ar_if ();
    axi_addr_remap_stage_if #(.AddrWidth(32)) mst_ar_if ();

    axi_addr_remap_stage #(
        .NumRules(4), .SlvAddrWidth(32), .MstAddrWidth(32)
    ) dut (
        .clk(clk), .rst(rst),
        .slv_aw(slv_aw_if), .mst_aw(mst_aw_if), .slv_ar(slv_ar_if), .mst_ar(mst_ar_if),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_base(cfg_base),
        .cfg_mask(cfg_mask), .cfg_offset(cfg_offset), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: rule table, one queue of pending downstream beats per channel.
    bit          m_en   [4];
    logic [31:0] m_base [4];
    logic [31:0] m_mask [4];
    logic [31:0] m_off  [4];
    logic [31:0] aw_q[$];
    logic [31:0] ar_q[$];
    int unsigned exp_miss;

    function automatic logic [31:0] xlat(input logic [31:0] a, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_en[i] && (((a ^ m_base[i]) & m_mask[i]) == 32'h0)) begin
                hit = 1'b1;
                return (m_off[i] & m_mask[i]) | (a & ~m_mask[i]);
            end
        end
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 1'b0; m_base[i] = '0; m_mask[i] = '0; m_off[i] = '0;
        end
        aw_q.delete();
        ar_q.delete();
        exp_miss = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs at the falling edge, advance the model across the next rising edge.
    task automatic tick();
        bit aw_rdy, ar_rdy, aw_cap, ar_cap, aw_h, ar_h;
        logic [31:0] aw_t, ar_t;
        int unsigned n;
        @(negedge clk);
        aw_rdy = (aw_q.size() == 0) || mst_aw_if.ready;
        ar_rdy = (ar_q.size() == 0) || mst_ar_if.ready;
        chk("aw_valid", 32'(mst_aw_if.valid), 32'(aw_q.size() != 0));
        chk("ar_valid", 32'(mst_ar_if.valid), 32'(ar_q.size() != 0));
        chk("aw_slv_ready", 32'(slv_aw_if.ready), 32'(aw_rdy));
        chk("ar_slv_ready", 32'(slv_ar_if.ready), 32'(ar_rdy));
        if (aw_q.size() != 0) chk("aw_addr", mst_aw_if.addr, aw_q[0]);
        if (ar_q.size() != 0) chk("ar_addr", mst_ar_if.addr, ar_q[0]);
        chk("miss_cnt", 32'(miss_cnt), exp_miss);
        if (rst) begin
            model_reset();
        end else begin
            aw_cap = slv_aw_if.valid && aw_rdy;
            ar_cap = slv_ar_if.valid && ar_rdy;
            aw_t = xlat(slv_aw_if.addr, aw_h);
            ar_t = xlat(slv_ar_if.addr, ar_h);
            if (aw_q.size() != 0 && mst_aw_if.ready) void'(aw_q.pop_front());
            if (ar_q.size() != 0 && mst_ar_if.ready) void'(ar_q.pop_front());
            if (aw_cap) aw_q.push_back(aw_t);
            if (ar_cap) ar_q.push_back(ar_t);
            n = int'(aw_cap && !aw_h) + int'(ar_cap && !ar_h);
`ifdef AXI_REMAP_MISS_CNT_EN
            exp_miss = (exp_miss + n > 32'hFFFF) ? 32'hFFFF : exp_miss + n;
`else
            n = 0;
`endif
            if (cfg_we) begin
                m_en[cfg_idx]   = cfg_en;
                m_base[cfg_idx] = cfg_base;
                m_mask[cfg_idx] = cfg_mask;
                m_off[cfg_idx]  = cfg_offset;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_rule(input logic [1:0] idx, input logic en, input logic [31:0] base,
                            input logic [31:0] mask, input logic [31:0] off);
        cfg_idx = idx; cfg_en = en; cfg_base = base; cfg_mask = mask; cfg_offset = off;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    logic [31:0] masks [4];

    initial begin
        masks = '{32'hF000_0000, 32'hFF00_0000, 32'h0000_0000, 32'hFFFF_F000};
        rst = 1'b1; cfg_we = 1'b0; cfg_en = 1'b0; cfg_idx = '0;
        cfg_base = '0; cfg_mask = '0; cfg_offset = '0;
        slv_aw_if.valid = 1'b0; slv_aw_if.addr = '0; mst_aw_if.ready = 1'b1;
        slv_ar_if.valid = 1'b0; slv_ar_if.addr = '0; mst_ar_if.ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        tick();
        chk("rst_aw_addr", mst_aw_if.addr, 32'h0);
        chk("rst_ar_addr", mst_ar_if.addr, 32'h0);
        rst = 1'b0;

        // Pass-through with an empty table.
        slv_aw_if.valid = 1'b1; slv_aw_if.addr = 32'h1234_5678;
        tick();
        slv_aw_if.valid = 1'b0;
        chk("pt_valid", 32'(mst_aw_if.valid), 32'd1);
        chk("pt_addr", mst_aw_if.addr, 32'h1234_5678);
        tick();
        chk("pt_one_cycle", 32'(mst_aw_if.valid), 32'd0);

        // Remap and priority.
        set_rule(2'd0, 1'b1, 32'h8000_0000, 32'hF000_0000, 32'h2000_0000);
        slv_ar_if.valid = 1'b1; slv_ar_if.addr = 32'h8000_0040;
        tick();
        slv_ar_if.valid = 1'b0;
        chk("remap", mst_ar_if.addr, 32'h2000_0040);
        tick();
        set_rule(2'd1, 1'b1, 32'h8000_0000, 32'hF000_0000, 32'h3000_0000);
        slv_ar_if.valid = 1'b1;
        tick();
        slv_ar_if.valid = 1'b0;
        chk("prio_rule0", mst_ar_if.addr, 32'h2000_0040);
        tick();
        set_rule(2'd0, 1'b0, 32'h8000_0000, 32'hF000_0000, 32'h2000_0000);
        slv_ar_if.valid = 1'b1;
        tick();
        slv_ar_if.valid = 1'b0;
        chk("prio_rule1", mst_ar_if.addr, 32'h3000_0040);
        tick();

        // Backpressure with a pending beat and a table write during the stall.
        mst_aw_if.ready = 1'b0;
        slv_aw_if.valid = 1'b1; slv_aw_if.addr = 32'h8000_0100;
        tick();
        slv_aw_if.addr = 32'h1234_0000;
        for (int k = 0; k < 5; k++) begin
            cfg_idx = 2'd1; cfg_en = 1'b1; cfg_base = 32'h8000_0000;
            cfg_mask = 32'hF000_0000; cfg_offset = 32'h5000_0000;
            cfg_we = (k == 2);
            tick();
            chk("bp_slv_ready", 32'(slv_aw_if.ready), 32'd0);
            chk("bp_hold", mst_aw_if.addr, 32'h3000_0100);
        end
        cfg_we = 1'b0;
        mst_aw_if.ready = 1'b1;
        tick();
        slv_aw_if.valid = 1'b0;
        chk("bp_second", mst_aw_if.addr, 32'h1234_0000);
        tick();
        tick();

        // Back-to-back AR beats, reset mid-stream.
        for (int k = 0; k < 8; k++) begin
            slv_ar_if.valid = 1'b1; slv_ar_if.addr = $urandom;
            tick();
            chk("b2b_valid", 32'(mst_ar_if.valid), 32'd1);
        end
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", 32'(mst_ar_if.valid), 32'd0);
        rst = 1'b0; slv_ar_if.valid = 1'b0;
        tick();

        // Simultaneous misses on both channels.
        slv_aw_if.valid = 1'b1; slv_aw_if.addr = 32'h0000_1000;
        slv_ar_if.valid = 1'b1; slv_ar_if.addr = 32'h0000_2000;
        tick();
`ifdef AXI_REMAP_MISS_CNT_EN
        chk("miss_pair", 32'(miss_cnt), 32'd2);
        for (int k = 0; k < 32766; k++) tick();
        slv_aw_if.valid = 1'b0; slv_ar_if.valid = 1'b0;
        tick();
        chk("miss_preload", 32'(miss_cnt), 32'hFFFE);
        slv_aw_if.valid = 1'b1; slv_ar_if.valid = 1'b1;
        tick();
        chk("miss_sat", 32'(miss_cnt), 32'hFFFF);
        tick();
        chk("miss_sat_hold", 32'(miss_cnt), 32'hFFFF);
`else
        chk("miss_tied", 32'(miss_cnt), 32'd0);
`endif
        slv_aw_if.valid = 1'b0; slv_ar_if.valid = 1'b0;
        tick();

        // Random traffic and table updates.
        for (int k = 0; k < 600; k++) begin
            slv_aw_if.valid = ($urandom_range(0, 3) != 0);
            slv_ar_if.valid = ($urandom_range(0, 3) != 0);
            slv_aw_if.addr  = {4'($urandom_range(7, 9)), 28'($urandom)};
            slv_ar_if.addr  = {4'($urandom_range(7, 9)), 28'($urandom)};
            mst_aw_if.ready = ($urandom_range(0, 2) != 0);
            mst_ar_if.ready = ($urandom_range(0, 2) != 0);
            cfg_we     = ($urandom_range(0, 5) == 0);
            cfg_idx    = 2'($urandom_range(0, 3));
            cfg_en     = ($urandom_range(0, 3) != 0);
            cfg_base   = {4'($urandom_range(7, 9)), 28'($urandom)};
            cfg_mask   = masks[$urandom_range(0, 3)];
            cfg_offset = $urandom;
            tick();
        end
        cfg_we = 1'b0;
        slv_aw_if.valid = 1'b0; slv_ar_if.valid = 1'b0;
        mst_aw_if.ready = 1'b1; mst_ar_if.ready = 1'b1;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
